// File: rtl/wb_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_guard
// Description : Wishbone classic pass-through between a CPU master port and
//               the interconnect. A strobe left unanswered for TIMEOUT_CYCLES
//               cycles is ended with a single-cycle error to the master. The
//               downstream cycle is dropped in that cycle. The first faulting
//               address and direction are recorded, and a saturating count of
//               timeouts is kept.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   wbs_*_i / wbs_*_o          master-facing Wishbone slave port
//   wbm_*_o / wbm_*_i          interconnect-facing Wishbone master port
//   fault_adr_o, fault_we_o    capture of the first timed-out cycle
//   fault_valid_o              sticky "a timeout happened" flag
//   fault_cnt_o                saturating timeout count (0..255)
//   fault_clr_i                synchronous clear of all fault registers
// ============================================================================
module wb_timeout_guard #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    // Master side
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic [2:0]  wbs_cti_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    // Interconnect side
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    // Fault record
    output logic [31:0] fault_adr_o,
    output logic        fault_we_o,
    output logic        fault_valid_o,
    output logic [7:0]  fault_cnt_o,
    input  logic        fault_clr_i
);

    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_TERM = 1'b1
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [31:0]          r_fault_adr;
    logic                 r_fault_we;
    logic                 r_fault_valid;
    logic [7:0]           r_fault_cnt;

    logic w_req;
    logic w_resp;
    logic w_term;
    logic w_timeout;

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_resp    = wbm_ack_i | wbm_err_i;
    assign w_term    = (r_state == ST_TERM);
    // A downstream response in the same cycle wins over the timeout.
    assign w_timeout = (r_state == ST_PASS) & w_req & ~w_resp & (r_cnt == C_LAST);

    // ------------------------------------------------------------------------
    // Forwarding paths. Address/data/controls are passed through unchanged.
    // In TERM the downstream cycle is withdrawn and the master sees only err.
    // ------------------------------------------------------------------------
    assign wbm_adr_o = wbs_adr_i;
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_sel_o = wbs_sel_i;
    assign wbm_we_o  = wbs_we_i;
    assign wbm_cti_o = wbs_cti_i;
    assign wbm_cyc_o = wbs_cyc_i & ~w_term;
    assign wbm_stb_o = wbs_stb_i & ~w_term;

    assign wbs_dat_o = w_term ? 32'h0 : wbm_dat_i;
    assign wbs_err_o = w_term | wbm_err_i;
    // Err has priority so ack and err are never presented together.
    assign wbs_ack_o = ~w_term & wbm_ack_i & ~wbm_err_i;

    // ------------------------------------------------------------------------
    // State machine and wait counter
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_PASS;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_PASS: begin
                    if (w_timeout) begin
                        r_state <= ST_TERM;
                        r_cnt   <= '0;
                    end else if (!w_req || w_resp) begin
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + C_ONE;
                    end
                end
                ST_TERM: begin
                    r_state <= ST_PASS;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_PASS;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fault record. A clear coinciding with a timeout keeps the new fault,
    // so the record then describes that fault alone with a count of one.
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_fault_adr   <= 32'h0;
            r_fault_we    <= 1'b0;
            r_fault_valid <= 1'b0;
            r_fault_cnt   <= 8'd0;
        end else if (fault_clr_i) begin
            if (w_timeout) begin
                r_fault_adr   <= wbs_adr_i;
                r_fault_we    <= wbs_we_i;
                r_fault_valid <= 1'b1;
                r_fault_cnt   <= 8'd1;
            end else begin
                r_fault_adr   <= 32'h0;
                r_fault_we    <= 1'b0;
                r_fault_valid <= 1'b0;
                r_fault_cnt   <= 8'd0;
            end
        end else if (w_timeout) begin
            if (!r_fault_valid) begin
                r_fault_adr   <= wbs_adr_i;
                r_fault_we    <= wbs_we_i;
                r_fault_valid <= 1'b1;
            end
            if (r_fault_cnt != 8'hFF) begin
                r_fault_cnt <= r_fault_cnt + 8'd1;
            end
        end
    end

    assign fault_adr_o   = r_fault_adr;
    assign fault_we_o    = r_fault_we;
    assign fault_valid_o = r_fault_valid;
    assign fault_cnt_o   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_timeout_guard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_timeout_guard
// Description : Directed bench for wb_timeout_guard with TIMEOUT_CYCLES = 8.
//               Table of single-cycle pass-through vectors plus hand-written
//               multi-cycle sequences for timeout, race, clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timeout_guard;

    localparam int TIMEOUT_CYCLES = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [2:0]  wbs_cti_i;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic        wbm_ack_i, wbm_err_i;
    logic [31:0] fault_adr_o;
    logic        fault_we_o, fault_valid_o, fault_clr_i;
    logic [7:0]  fault_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_timeout_guard #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_WIDTH(16)) dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .wbs_adr_i    (wbs_adr_i),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_sel_i    (wbs_sel_i),
        .wbs_we_i     (wbs_we_i),
        .wbs_cyc_i    (wbs_cyc_i),
        .wbs_stb_i    (wbs_stb_i),
        .wbs_cti_i    (wbs_cti_i),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_ack_o    (wbs_ack_o),
        .wbs_err_o    (wbs_err_o),
        .wbm_adr_o    (wbm_adr_o),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_sel_o    (wbm_sel_o),
        .wbm_we_o     (wbm_we_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbm_stb_o    (wbm_stb_o),
        .wbm_cti_o    (wbm_cti_o),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack_i),
        .wbm_err_i    (wbm_err_i),
        .fault_adr_o  (fault_adr_o),
        .fault_we_o   (fault_we_o),
        .fault_valid_o(fault_valid_o),
        .fault_cnt_o  (fault_cnt_o),
        .fault_clr_i  (fault_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [31:0] mdat;
        logic        ack;
        logic        err;
        logic        e_mcyc;
        logic        e_mstb;
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_dat;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wbs_cyc_i   = 1'b0;
        wbs_stb_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;
        fault_clr_i = 1'b0;
    endtask

    task automatic start_req(input logic [31:0] adr, input logic we);
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
    endtask

    // Full unanswered transfer: cycles 0..7 waiting, err in cycle 8.
    // With clr_in_last set, fault_clr_i is raised in the TERM-entry cycle.
    task automatic do_timeout(input logic [31:0] adr, input logic we, input logic clr_in_last);
        start_req(adr, we);
        for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
            fault_clr_i = clr_in_last && (i == TIMEOUT_CYCLES - 1);
            tick();
        end
        fault_clr_i = 1'b0;
        #2;
        check("timeout_err", {63'd0, wbs_err_o}, 64'd1);
        tick();
        idle_inputs();
        tick();
    endtask

    int n_err;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'h1111_2222, 4'hF, 3'd0, 32'h0000_DEAD,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_DEAD};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h2000_0004, 32'h0, 4'hF, 3'd0, 32'h1234_5678,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h3000_0008, 32'hA5A5_5A5A, 4'h3, 3'd7, 32'h0,
                    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h1, 3'd0, 32'h7777_0000,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7777_0000};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32'h5000_0010, 32'hFEED_BEEF, 4'hC, 3'd2, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h6000_0020, 32'h0BAD_F00D, 4'h8, 3'd0, 32'h0,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        wbs_sel_i = 4'h0;
        wbs_cti_i = 3'd0;
        wbm_dat_i = 32'h0;
        idle_inputs();

        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst_valid", {63'd0, fault_valid_o}, 64'd0);
        check("rst_cnt", {56'd0, fault_cnt_o}, 64'd0);
        check("rst_err", {63'd0, wbs_err_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-cycle pass-through table
        for (int i = 0; i < 6; i++) begin
            wbs_cyc_i = vecs[i].cyc;
            wbs_stb_i = vecs[i].stb;
            wbs_we_i  = vecs[i].we;
            wbs_adr_i = vecs[i].adr;
            wbs_dat_i = vecs[i].dat;
            wbs_sel_i = vecs[i].sel;
            wbs_cti_i = vecs[i].cti;
            wbm_dat_i = vecs[i].mdat;
            wbm_ack_i = vecs[i].ack;
            wbm_err_i = vecs[i].err;
            #2;
            check($sformatf("vec%0d_adr_dat", i), {wbm_adr_o, wbm_dat_o}, {vecs[i].adr, vecs[i].dat});
            check($sformatf("vec%0d_ctl", i),
                  {54'd0, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o},
                  {54'd0, vecs[i].sel, vecs[i].we, vecs[i].e_mcyc, vecs[i].e_mstb, vecs[i].cti});
            check($sformatf("vec%0d_resp", i), {30'd0, wbs_ack_o, wbs_err_o, wbs_dat_o},
                  {30'd0, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_dat});
            tick();
        end
        idle_inputs();
        tick();

        // Read acked in cycle 3
        start_req(32'h1000_0040, 1'b0);
        wbm_dat_i = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            wbm_ack_i = (c == 3);
            #2;
            check($sformatf("rd_c%0d_ack", c), {63'd0, wbs_ack_o}, {63'd0, (c == 3)});
            check($sformatf("rd_c%0d_err", c), {63'd0, wbs_err_o}, 64'd0);
            if (c == 3) check("rd_dat", {32'd0, wbs_dat_o}, 64'hCAFE_F00D);
            tick();
        end
        idle_inputs();
        #2;
        check("rd_fault_valid", {63'd0, fault_valid_o}, 64'd0);
        tick();

        // Write to a silent slave; a stray ack in the TERM cycle is dropped
        start_req(32'h9000_0010, 1'b1);
        wbm_dat_i = 32'h5555_AAAA;
        for (int c = 0; c < TIMEOUT_CYCLES; c++) begin
            #2;
            check($sformatf("wr_c%0d_err", c), {62'd0, wbs_err_o, wbm_cyc_o}, 64'd1);
            tick();
        end
        wbm_ack_i = 1'b1;
        #2;
        check("term_err_ack", {62'd0, wbs_err_o, wbs_ack_o}, 64'd2);
        check("term_cyc_stb", {62'd0, wbm_cyc_o, wbm_stb_o}, 64'd0);
        check("term_dat", {32'd0, wbs_dat_o}, 64'd0);
        tick();
        idle_inputs();
        #2;
        check("post_term_err", {63'd0, wbs_err_o}, 64'd0);
        check("fault_adr", {32'd0, fault_adr_o}, 64'h9000_0010);
        check("fault_we_valid", {62'd0, fault_we_o, fault_valid_o}, 64'd3);
        check("fault_cnt1", {56'd0, fault_cnt_o}, 64'd1);
        tick();

        // Ack in the last possible cycle wins over the timeout
        start_req(32'h1000_0080, 1'b0);
        for (int c = 0; c < TIMEOUT_CYCLES; c++) begin
            wbm_ack_i = (c == TIMEOUT_CYCLES - 1);
            #2;
            if (c == TIMEOUT_CYCLES - 1)
                check("race_resp", {62'd0, wbs_ack_o, wbs_err_o}, 64'd2);
            tick();
        end
        idle_inputs();
        #2;
        check("race_no_err", {63'd0, wbs_err_o}, 64'd0);
        check("race_cnt", {56'd0, fault_cnt_o}, 64'd1);
        tick();

        // Master withdraws mid-wait: counter restarts, no error
        n_err = 0;
        start_req(32'h1000_00C0, 1'b0);
        for (int c = 0; c < 13; c++) begin
            wbs_stb_i = (c != 5);
            #2;
            if (wbs_err_o) n_err++;
            tick();
        end
        idle_inputs();
        check("drop_no_err", 64'(n_err), 64'd0);
        check("drop_cnt", {56'd0, fault_cnt_o}, 64'd1);
        tick();

        // Clear, then two timeouts: first capture kept, count 2, then clear
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
        #2;
        check("clr1_all", {23'd0, fault_valid_o, fault_we_o, fault_cnt_o, fault_adr_o}, 64'd0);
        do_timeout(32'h0000_00A0, 1'b0, 1'b0);
        do_timeout(32'h0000_00B0, 1'b1, 1'b0);
        check("two_adr", {32'd0, fault_adr_o}, 64'hA0);
        check("two_we", {63'd0, fault_we_o}, 64'd0);
        check("two_cnt", {56'd0, fault_cnt_o}, 64'd2);
        fault_clr_i = 1'b1;
        tick();
        fault_clr_i = 1'b0;
        #2;
        check("clr2_all", {23'd0, fault_valid_o, fault_we_o, fault_cnt_o, fault_adr_o}, 64'd0);
        tick();

        // Clear coincident with TERM entry keeps the new fault only
        do_timeout(32'h0000_00C0, 1'b0, 1'b0);
        do_timeout(32'h0000_00D0, 1'b1, 1'b1);
        check("clrhit_adr", {32'd0, fault_adr_o}, 64'hD0);
        check("clrhit_cnt", {55'd0, fault_valid_o, fault_cnt_o}, 64'h101);
        check("clrhit_we", {63'd0, fault_we_o}, 64'd1);

        // 300 back-to-back timeouts with the strobe held: count saturates
        n_err = 0;
        start_req(32'h0000_0E00, 1'b0);
        for (int c = 0; c < 9 * 300; c++) begin
            #2;
            if (wbs_err_o) n_err++;
            tick();
        end
        idle_inputs();
        check("sat_err_pulses", 64'(n_err), 64'd300);
        check("sat_cnt", {56'd0, fault_cnt_o}, 64'd255);
        check("sat_adr", {32'd0, fault_adr_o}, 64'hD0);
        tick();

        // Reset asserted in the middle of TERM
        start_req(32'h0000_0F00, 1'b1);
        for (int c = 0; c < TIMEOUT_CYCLES; c++) tick();
        #2;
        check("pre_rst_err", {63'd0, wbs_err_o}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_term_err", {63'd0, wbs_err_o}, 64'd0);
        check("rst_term_fault", {23'd0, fault_valid_o, fault_we_o, fault_cnt_o, fault_adr_o}, 64'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        start_req(32'h2000_0100, 1'b0);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0123_4567;
        #2;
        check("after_rst_pass", {29'd0, wbm_cyc_o, wbs_ack_o, wbs_err_o, wbs_dat_o},
              {29'd0, 3'b110, 32'h0123_4567});
        tick();
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wb_timeout_guard.md
WB_TIMEOUT_GUARD -- requirements
Module: wb_timeout_guard

Purpose: Wishbone classic pass-through between the picorv32_wb master port and the interconnect master input. Terminates hung cycles with an error and records the fault.

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of unacknowledged strobe cycles before the guard terminates the cycle; legal range 2..65535.
REQ-002 Parameter CNT_WIDTH, default 16: width of the wait counter; SHALL satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.
REQ-003 wb_clk_i  in  1  single clock; every register samples on its rising edge.
REQ-004 wb_rst_ni  in  1  reset; asynchronous assertion, active-low.
REQ-005 wbs_adr_i, wbs_dat_i  in  32 each  master address and write data.
REQ-006 wbs_sel_i  in  4  master byte selects.
REQ-007 wbs_we_i, wbs_cyc_i, wbs_stb_i  in  1 each  master write enable, cycle and strobe.
REQ-008 wbs_cti_i  in  3  master cycle type identifier; bursts are not supported.
REQ-009 wbs_dat_o  out  32  read data returned to the master.
REQ-010 wbs_ack_o, wbs_err_o  out  1 each  acknowledge and error to the master.
REQ-011 wbm_adr_o, wbm_dat_o  out  32 each  address and write data forwarded downstream.
REQ-012 wbm_sel_o  out  4  byte selects forwarded downstream.
REQ-013 wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1 each  forwarded write enable, cycle and strobe.
REQ-014 wbm_cti_o  out  3  forwarded cycle type identifier.
REQ-015 wbm_dat_i  in  32  downstream read data.
REQ-016 wbm_ack_i, wbm_err_i  in  1 each  downstream acknowledge and error.
REQ-017 fault_adr_o  out  32  captured address of the first timed-out cycle.
REQ-018 fault_we_o  out  1  captured write enable of the first timed-out cycle.
REQ-019 fault_valid_o  out  1  sticky flag: a timeout has occurred.
REQ-020 fault_cnt_o  out  8  saturating count of timeouts.
REQ-021 fault_clr_i  in  1  synchronous clear of all fault registers.

Function
REQ-022 The guard SHALL have exactly two states, PASS and TERM; reset state is PASS.
REQ-023 In PASS, adr/dat/sel/we/cti SHALL be forwarded combinationally, as SHALL wbm_cyc_o=wbs_cyc_i and wbm_stb_o=wbs_stb_i.
- Downstream ack, err and dat SHALL be returned combinationally, zero added latency.
REQ-024 Wait counter: cleared to 0 in any cycle with !(wbs_cyc_i&wbs_stb_i), wbm_ack_i or wbm_err_i; otherwise incremented by 1.
REQ-025 PASS->TERM when wbs_cyc_i&wbs_stb_i, no wbm_ack_i/wbm_err_i, and counter==TIMEOUT_CYCLES-1.
- Effect: strobe first seen in cycle 0 with no response gives wbs_err_o=1 in cycle TIMEOUT_CYCLES.
REQ-026 TERM SHALL last exactly one cycle, then return to PASS with counter=0. During TERM:
- wbs_err_o=1, wbs_ack_o=0, wbs_dat_o=0.
- wbm_cyc_o=0, wbm_stb_o=0.
- A downstream ack/err in the TERM cycle SHALL be discarded.
REQ-027 Simultaneous events: ack/err arriving in the same cycle the counter reaches TIMEOUT_CYCLES-1 SHALL win. The cycle completes normally and no timeout is recorded.
REQ-028 On TERM entry with fault_valid_o=0: capture wbs_adr_i and wbs_we_i, then set fault_valid_o. Later timeouts SHALL NOT overwrite the capture while fault_valid_o=1.
REQ-029 fault_cnt_o SHALL increment on each TERM entry and saturate at 255.
REQ-030 fault_clr_i=1 SHALL clear fault_valid_o, fault_adr_o, fault_we_o and fault_cnt_o on the next edge.
- If the clear coincides with a TERM entry, the new fault SHALL be captured and fault_cnt_o SHALL equal 1.
REQ-031 Master dropping cyc/stb mid-wait SHALL clear the counter with no error signalled.
REQ-032 wbs_ack_o and wbs_err_o SHALL never both be 1.

Reset
REQ-033 Asserting wb_rst_ni low SHALL immediately force: state=PASS, counter=0, fault_valid_o=0, fault_adr_o=0, fault_we_o=0, fault_cnt_o=0.
REQ-034 Reset mid-TERM SHALL drop wbs_err_o at once. After deassertion, pass-through SHALL resume on the first clock edge.

Verification
REQ-035 Read with ack in cycle 3 (TIMEOUT_CYCLES=8) -> wbs_ack_o in cycle 3, dat passed through, fault_valid_o=0.
REQ-036 Write to a non-responding slave, adr=0x9000_0010 (TIMEOUT_CYCLES=8) -> wbs_err_o=1 in cycle 8 only, wbm_cyc_o=0 in cycle 8, fault_adr_o=0x9000_0010, fault_we_o=1, fault_cnt_o=1.
REQ-037 Ack arriving in cycle 7 (TIMEOUT_CYCLES=8) -> normal ack, no error, fault_cnt_o unchanged.
REQ-038 Two consecutive timeouts at 0xA0 then 0xB0 -> fault_adr_o=0xA0, fault_cnt_o=2. Then fault_clr_i pulse -> all fault outputs 0.
REQ-039 300 timeouts -> fault_cnt_o saturates at 255.
REQ-040 wb_rst_ni low during TERM -> wbs_err_o=0 immediately, all fault registers 0. Next cycle after release -> normal pass-through.
